// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 packet framer.
package ps2_pkg;

    typedef enum logic {
        SEEK    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    localparam int unsigned SYNC_BIT_DEFAULT = 3;
    localparam int unsigned LEN_W            = 4;

endpackage

// File: rtl/ps2_idle_timer.sv
// Counts consecutive idle cycles and flags expiry after LIMIT of them.
module ps2_idle_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry fires on the LIMIT-th idle edge itself, so the abort lands on that edge.
    assign expire = run && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_packet_framer.sv
// Frames a PS/2 byte stream into 3- or MAX_BYTES-byte packets, seeking on a sync bit.
module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = 4,
    parameter int unsigned SYNC_BIT    = SYNC_BIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in,
    input  logic                   in_valid,
    input  logic                   ext_mode,
    output logic                   done,
    output logic [8*MAX_BYTES-1:0] out_bytes,
    output logic [LEN_W-1:0]       out_len,
    output logic                   timeout_err,
    output logic [7:0]             discard_cnt
);

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       pkt_len_q, pkt_len_d;
    logic [8*MAX_BYTES-1:0] pkt_q, pkt_d;
    logic [8*MAX_BYTES-1:0] out_bytes_q, out_bytes_d;
    logic [LEN_W-1:0]       out_len_q, out_len_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [7:0]             discard_q, discard_d;
    logic                   expire;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            logic idle_run, idle_clear;
            assign idle_run   = (state_q == COLLECT) && !in_valid;
            assign idle_clear = (state_q != COLLECT) || in_valid;

            ps2_idle_timer #(
                .LIMIT(TIMEOUT_CYC)
            ) u_idle_timer (
                .clk   (clk),
                .reset (reset),
                .clear (idle_clear),
                .run   (idle_run),
                .expire(expire)
            );
        end else begin : g_no_timer
            assign expire = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pkt_len_d   = pkt_len_q;
        pkt_d       = pkt_q;
        out_bytes_d = out_bytes_q;
        out_len_d   = out_len_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        discard_d   = discard_q;

        case (state_q)
            SEEK: begin
                if (in_valid) begin
                    if (in[SYNC_BIT]) begin
                        // Clearing first keeps unused lanes of a short packet at zero.
                        pkt_d                        = '0;
                        pkt_d[8*MAX_BYTES-1 -: 8]    = in;
                        pkt_len_d = ext_mode ? LEN_W'(MAX_BYTES) : LEN_W'(3);
                        idx_d     = LEN_W'(1);
                        state_d   = COLLECT;
                    end else if (discard_q != 8'hFF) begin
                        discard_d = discard_q + 8'd1;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    for (int i = 1; i < MAX_BYTES; i++) begin
                        if (idx_q == LEN_W'(i)) begin
                            pkt_d[8*(MAX_BYTES-1-i) +: 8] = in;
                        end
                    end
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == pkt_len_q - LEN_W'(1)) begin
                        out_bytes_d = pkt_d;
                        out_len_d   = pkt_len_q;
                        done_d      = 1'b1;
                        idx_d       = '0;
                        state_d     = SEEK;
                    end
                end else if (expire) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = SEEK;
                end
            end
            default: begin
                state_d = SEEK;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEEK;
            idx_q       <= '0;
            pkt_len_q   <= LEN_W'(3);
            pkt_q       <= '0;
            out_bytes_q <= '0;
            out_len_q   <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            discard_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pkt_len_q   <= pkt_len_d;
            pkt_q       <= pkt_d;
            out_bytes_q <= out_bytes_d;
            out_len_q   <= out_len_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            discard_q   <= discard_d;
        end
    end

    assign done        = done_q;
    assign out_bytes   = out_bytes_q;
    assign out_len     = out_len_q;
    assign timeout_err = timeout_q;
    assign discard_cnt = discard_q;

endmodule
